// File: rtl/conversor_bin_bcd_pkg.sv
// Shared types, constants and helpers for the sequential binary-to-BCD converter.
package conversor_bin_bcd_pkg;

  typedef enum logic [0:0] {
    REPOSO       = 1'b0,
    CONVIRTIENDO = 1'b1
  } estado_e;

  localparam logic [3:0] DIGITO_AJUSTE = 4'd5;
  localparam logic [3:0] SUMA_AJUSTE   = 4'd3;

  function automatic int ancho_bcd(input int n_digitos);
    return 4 * n_digitos;
  endfunction

  function automatic int clog2(input int valor);
    int r;
    int v;
    r = 0;
    v = valor - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/conversor_bin_bcd_if.sv
// start/done handshake and data bus of the binary-to-BCD converter.
interface conversor_bin_bcd_if
  import conversor_bin_bcd_pkg::*;
#(
  parameter int N_BITS    = 8,
  parameter int N_DIGITOS = 3
);
  logic                           inicio;
  logic [N_BITS-1:0]              binario;
  logic                           ocupado;
  logic                           listo;
  logic [ancho_bcd(N_DIGITOS)-1:0] bcd;
  logic                           desborde;

  modport master (output inicio, output binario,
                  input  ocupado, input listo, input bcd, input desborde);
  modport slave  (input  inicio, input binario,
                  output ocupado, output listo, output bcd, output desborde);
endinterface

// File: rtl/conversor_bin_bcd_ajuste_add3.sv
// Single-digit correction of shift-and-add-3: digits of 5 or more get +3 before the shift.
module ajuste_add3
  import conversor_bin_bcd_pkg::*;
(
  input  logic [3:0] digito_i,
  output logic [3:0] digito_o
);

  // digit correction
  always_comb begin
    if (digito_i >= DIGITO_AJUSTE) begin
      digito_o = digito_i + SUMA_AJUSTE;
    end else begin
      digito_o = digito_i;
    end
  end

endmodule

// File: rtl/conversor_bin_bcd.sv
// Sequential binary-to-BCD converter, one bit per clock; result held until the next conversion.
module conversor_bin_bcd
  import conversor_bin_bcd_pkg::*;
#(
  parameter int N_BITS    = 8,
  parameter int N_DIGITOS = 3
)(
  input  logic               clk,
  input  logic               rst_n,
  conversor_bin_bcd_if.slave bus
);

  localparam int ANCHO_BCD = ancho_bcd(N_DIGITOS);
  localparam int ANCHO_CNT = clog2(N_BITS + 1);
  localparam logic [ANCHO_CNT-1:0] CNT_ULTIMO = ANCHO_CNT'(N_BITS - 1);
  localparam logic [ANCHO_CNT-1:0] CNT_UNO    = ANCHO_CNT'(1);

  estado_e              estado_q, estado_d;
  logic [ANCHO_CNT-1:0] cnt_q, cnt_d;
  logic [N_BITS-1:0]    shift_q, shift_d;
  logic [ANCHO_BCD-1:0] digitos_q, digitos_d;
  logic                 sticky_q, sticky_d;
  logic                 ocupado_q, ocupado_d;
  logic                 listo_q, listo_d;
  logic [ANCHO_BCD-1:0] bcd_q, bcd_d;
  logic                 desborde_q, desborde_d;
  logic [ANCHO_BCD-1:0] ajustados_s;

  for (genvar g = 0; g < N_DIGITOS; g++) begin : g_ajuste
    ajuste_add3 u_ajuste (
      .digito_i (digitos_q[4*g +: 4]),
      .digito_o (ajustados_s[4*g +: 4])
    );
  end

  // next-state and datapath for one shift iteration per clock
  always_comb begin
    estado_d   = estado_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    digitos_d  = digitos_q;
    sticky_d   = sticky_q;
    ocupado_d  = ocupado_q;
    listo_d    = 1'b0;
    bcd_d      = bcd_q;
    desborde_d = desborde_q;
    case (estado_q)
      REPOSO: begin
        if (bus.inicio) begin
          estado_d  = CONVIRTIENDO;
          shift_d   = bus.binario;
          digitos_d = '0;
          sticky_d  = 1'b0;
          cnt_d     = '0;
          ocupado_d = 1'b1;
        end else begin
          estado_d  = REPOSO;
        end
      end
      CONVIRTIENDO: begin
        // the bit leaving the top digit is lost, so the kept digits stay value mod 10^N_DIGITOS
        digitos_d = {ajustados_s[ANCHO_BCD-2:0], shift_q[N_BITS-1]};
        shift_d   = shift_q << 1;
        sticky_d  = sticky_q | ajustados_s[ANCHO_BCD-1];
        cnt_d     = cnt_q + CNT_UNO;
        if (cnt_q == CNT_ULTIMO) begin
          estado_d   = REPOSO;
          ocupado_d  = 1'b0;
          listo_d    = 1'b1;
          bcd_d      = {ajustados_s[ANCHO_BCD-2:0], shift_q[N_BITS-1]};
          desborde_d = sticky_q | ajustados_s[ANCHO_BCD-1];
        end else begin
          estado_d   = CONVIRTIENDO;
        end
      end
      default: begin
        estado_d  = REPOSO;
        ocupado_d = 1'b0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q   <= REPOSO;
      cnt_q      <= '0;
      shift_q    <= '0;
      digitos_q  <= '0;
      sticky_q   <= 1'b0;
      ocupado_q  <= 1'b0;
      listo_q    <= 1'b0;
      bcd_q      <= '0;
      desborde_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      digitos_q  <= digitos_d;
      sticky_q   <= sticky_d;
      ocupado_q  <= ocupado_d;
      listo_q    <= listo_d;
      bcd_q      <= bcd_d;
      desborde_q <= desborde_d;
    end
  end

  assign bus.ocupado  = ocupado_q;
  assign bus.listo    = listo_q;
  assign bus.bcd      = bcd_q;
  assign bus.desborde = desborde_q;

endmodule

// File: tb/tb_conversor_bin_bcd.sv
// Directed bench for conversor_bin_bcd: scoreboard of expected {desborde,bcd} popped on each listo.
module tb_conversor_bin_bcd;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic [12:0] exp_q[$];
  logic [12:0] ultimo;

  conversor_bin_bcd_if #(.N_BITS(8), .N_DIGITOS(3)) bif ();
  conversor_bin_bcd_if #(.N_BITS(8), .N_DIGITOS(2)) bif2 ();

  conversor_bin_bcd #(.N_BITS(8), .N_DIGITOS(3)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  conversor_bin_bcd #(.N_BITS(8), .N_DIGITOS(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  // decimal reference: {overflow, packed digits} computed by division
  function automatic logic [12:0] ref_model(input int v, input int nd);
    logic [11:0] d;
    int p;
    d = 12'h000;
    p = 1;
    for (int i = 0; i < nd; i++) begin
      d[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return {(v >= p), d};
  endfunction

  task automatic chk_resultado(input string tag);
    logic [12:0] e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s_spurious_listo bcd=%h expected no listo", tag, bif.bcd);
    end else begin
      e = exp_q.pop_front();
      assert ({bif.desborde, bif.bcd} === e) else begin
        n_err++;
        $error("FAIL %s desborde/bcd=%b/%h expected %b/%h", tag, bif.desborde, bif.bcd, e[12], e[11:0]);
      end
    end
    ultimo = {bif.desborde, bif.bcd};
  endtask

  task automatic chk_hold(input string tag);
    n_vec++;
    assert (bif.listo === 1'b0 && {bif.desborde, bif.bcd} === ultimo) else begin
      n_err++;
      $error("FAIL %s_hold listo=%b desborde/bcd=%b/%h expected 0 and %b/%h",
             tag, bif.listo, bif.desborde, bif.bcd, ultimo[12], ultimo[11:0]);
    end
  endtask

  task automatic esperar_listo(input string tag, input int limite, output bit hit, output int ocup, output int ciclos);
    hit = 1'b0;
    ocup = 0;
    ciclos = 0;
    for (int k = 0; k < limite && !hit; k++) begin
      @(negedge clk);
      ciclos++;
      if (bif.listo === 1'b1) begin
        hit = 1'b1;
        chk_resultado(tag);
      end else begin
        if (bif.ocupado === 1'b1) ocup++;
        chk_hold(tag);
      end
    end
    if (!hit) begin
      n_vec++;
      n_err++;
      $error("FAIL %s_timeout listo not seen within %0d clocks", tag, limite);
    end
  endtask

  task automatic inactivo(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk_hold(tag);
    end
  endtask

  // called at posedge+1; leaves at posedge+1
  task automatic convertir(input logic [7:0] v, input string tag);
    bit hit;
    int ocup;
    int ciclos;
    bif.binario = v;
    bif.inicio  = 1'b1;
    exp_q.push_back(ref_model(int'(v), 3));
    @(posedge clk);
    #1;
    bif.inicio  = 1'b0;
    bif.binario = ~v;
    esperar_listo(tag, 40, hit, ocup, ciclos);
    n_vec++;
    assert (hit && ocup == 8 && ciclos == 9 && bif.ocupado === 1'b0) else begin
      n_err++;
      $error("FAIL %s_timing ocupado_cycles=%0d listo_at=%0d expected 8 and 9", tag, ocup, ciclos);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic convertir2(input logic [7:0] v, input string tag);
    logic [12:0] e;
    bit hit;
    e = ref_model(int'(v), 2);
    bif2.binario = v;
    bif2.inicio  = 1'b1;
    @(posedge clk);
    #1;
    bif2.inicio = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      if (bif2.listo === 1'b1) hit = 1'b1;
    end
    n_vec++;
    assert (hit && {bif2.desborde, bif2.bcd} === {e[12], e[7:0]}) else begin
      n_err++;
      $error("FAIL %s listo=%b desborde/bcd=%b/%h expected 1 %b/%h", tag, hit, bif2.desborde, bif2.bcd, e[12], e[7:0]);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit hit;
    int ocup;
    int ciclos;
    n_vec = 0;
    n_err = 0;
    ultimo = 13'h0;
    bif.inicio = 1'b0;
    bif.binario = 8'h00;
    bif2.inicio = 1'b0;
    bif2.binario = 8'h00;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    assert ({bif.ocupado, bif.listo, bif.desborde, bif.bcd} === 15'h0000) else begin
      n_err++;
      $error("FAIL reset_state outputs=%h expected 0000", {bif.ocupado, bif.listo, bif.desborde, bif.bcd});
    end
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    convertir(8'd0,   "conv_0");
    convertir(8'd255, "conv_255");
    convertir(8'd99,  "conv_99");
    convertir(8'd100, "conv_100");

    // back-to-back ramp with inicio held high
    bif.binario = 8'd0;
    bif.inicio  = 1'b1;
    exp_q.push_back(ref_model(0, 3));
    for (int v = 0; v < 256; v++) begin
      esperar_listo("ramp", 20, hit, ocup, ciclos);
      if (v > 0) begin
        n_vec++;
        assert (ciclos == 9) else begin
          n_err++;
          $error("FAIL ramp_period value=%0d period=%0d expected 9", v, ciclos);
        end
      end
      if (v < 255) begin
        bif.binario = 8'(v + 1);
        exp_q.push_back(ref_model(v + 1, 3));
      end else begin
        bif.inicio = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    inactivo("ramp_end", 3);
    @(posedge clk);
    #1;

    // inicio pulses mid-conversion are ignored; binario changes after capture
    bif.binario = 8'd37;
    bif.inicio  = 1'b1;
    exp_q.push_back(ref_model(37, 3));
    @(posedge clk);
    #1;
    bif.inicio  = 1'b0;
    bif.binario = 8'd99;
    repeat (2) @(posedge clk);
    #1;
    bif.inicio = 1'b1;
    @(posedge clk);
    #1;
    bif.inicio = 1'b0;
    @(posedge clk);
    #1;
    bif.inicio = 1'b1;
    @(posedge clk);
    #1;
    bif.inicio = 1'b0;
    esperar_listo("no_restart", 20, hit, ocup, ciclos);
    inactivo("no_restart_after", 15);
    @(posedge clk);
    #1;

    // asynchronous reset in the middle of converting 200
    bif.binario = 8'd200;
    bif.inicio  = 1'b1;
    @(posedge clk);
    #1;
    bif.inicio = 1'b0;
    inactivo("pre_abort", 3);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    assert ({bif.ocupado, bif.listo, bif.desborde, bif.bcd} === 15'h0000) else begin
      n_err++;
      $error("FAIL abort_reset outputs=%h expected 0000", {bif.ocupado, bif.listo, bif.desborde, bif.bcd});
    end
    ultimo = 13'h0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    inactivo("after_abort", 12);
    @(posedge clk);
    #1;
    convertir(8'd7, "conv_7");

    convertir2(8'd100, "d2_100");
    convertir2(8'd99,  "d2_99");

    n_vec++;
    assert (exp_q.size() == 0) else begin
      n_err++;
      $error("FAIL scoreboard_left pending=%0d expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
